// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Control-bundle layout and write-back select encodings shared
//               by the pipeline control chain and its users.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    typedef struct packed {
        logic       reg_wr;
        logic       wr_en;
        logic       rd_en;
        logic [1:0] wb_sel;
        logic       csr_rd;
        logic       csr_wr;
        logic       is_mret;
    } ctrl_bundle_t;

    localparam int CTRL_W = $bits(ctrl_bundle_t);

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_CSR = 2'd3;

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_reg
// Description : One control-bundle stage with valid bit, hold, flush and
//               bubble insertion.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl_reg #(
    parameter int CTRL_W         = pipe_ctrl_pkg::CTRL_W,
    parameter bit ZERO_ON_BUBBLE = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold,
    input  logic              flush,
    input  logic              bubble,
    input  logic              d_valid,
    input  logic [CTRL_W-1:0] d_ctrl,
    output logic              q_valid,
    output logic [CTRL_W-1:0] q_ctrl
);

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;

    // Flush beats hold; a held stage only becomes a bubble when flushed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
            if (ZERO_ON_BUBBLE) r_ctrl <= '0;
        end else if (hold) begin
            r_valid <= r_valid;
            r_ctrl  <= r_ctrl;
        end else if (bubble) begin
            r_valid <= 1'b0;
            if (ZERO_ON_BUBBLE) r_ctrl <= '0;
        end else begin
            r_valid <= d_valid;
            r_ctrl  <= (ZERO_ON_BUBBLE && !d_valid) ? '0 : d_ctrl;
        end
    end

    assign q_valid = r_valid;
    assign q_ctrl  = r_ctrl;

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl_chain.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_chain
// Description : N-stage control-bundle pipeline with upstream back-pressure,
//               per-stage flush and saturating bubble/flush counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl_chain #(
    parameter int CTRL_W         = pipe_ctrl_pkg::CTRL_W,
    parameter int NUM_STG        = 3,
    parameter bit ZERO_ON_BUBBLE = 1'b1,
    parameter int CNT_W          = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic [CTRL_W-1:0]         in_ctrl,
    output logic                      in_ready,
    input  logic [NUM_STG-1:0]        stall,
    input  logic [NUM_STG-1:0]        flush,
    output logic [NUM_STG-1:0]        stg_valid,
    output logic [NUM_STG*CTRL_W-1:0] stg_ctrl,
    output logic [NUM_STG*CTRL_W-1:0] stg_ctrl_g,
    output logic [CNT_W-1:0]          bubble_cnt,
    output logic [CNT_W-1:0]          flush_cnt,
    input  logic                      cnt_clr
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [NUM_STG-1:0]        w_hold;
    logic [NUM_STG-1:0]        w_valid;
    logic [NUM_STG*CTRL_W-1:0] w_ctrl;
    logic [CNT_W-1:0]          r_bubble_cnt;
    logic [CNT_W-1:0]          r_flush_cnt;

    // A stall freezes its own stage and everything upstream of it.
    always_comb begin
        w_hold                = '0;
        w_hold[NUM_STG-1]     = stall[NUM_STG-1];
        for (int k = NUM_STG - 2; k >= 0; k--) begin
            w_hold[k] = stall[k] | w_hold[k+1];
        end
    end

    assign in_ready = ~w_hold[0];

    generate
        for (genvar k = 0; k < NUM_STG; k++) begin : g_stg
            logic              w_d_valid;
            logic [CTRL_W-1:0] w_d_ctrl;
            logic              w_bubble;

            if (k == 0) begin : g_head
                assign w_d_valid = in_valid;
                assign w_d_ctrl  = in_ctrl;
                assign w_bubble  = 1'b0;
            end else begin : g_body
                // Upstream frozen while this stage moves on: a bubble enters.
                assign w_d_valid = w_valid[k-1];
                assign w_d_ctrl  = w_ctrl[(k-1)*CTRL_W +: CTRL_W];
                assign w_bubble  = w_hold[k-1];
            end

            pipe_ctrl_reg #(
                .CTRL_W         (CTRL_W),
                .ZERO_ON_BUBBLE (ZERO_ON_BUBBLE)
            ) u_reg (
                .clk     (clk),
                .rst_n   (rst_n),
                .hold    (w_hold[k]),
                .flush   (flush[k]),
                .bubble  (w_bubble),
                .d_valid (w_d_valid),
                .d_ctrl  (w_d_ctrl),
                .q_valid (w_valid[k]),
                .q_ctrl  (w_ctrl[k*CTRL_W +: CTRL_W])
            );

            assign stg_ctrl_g[k*CTRL_W +: CTRL_W] =
                w_ctrl[k*CTRL_W +: CTRL_W] & {CTRL_W{w_valid[k]}};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else if (cnt_clr) begin
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else begin
            if (!w_valid[NUM_STG-1] && (r_bubble_cnt != CNT_MAX))
                r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
            if ((|flush) && (r_flush_cnt != CNT_MAX))
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
        end
    end

    assign stg_valid  = w_valid;
    assign stg_ctrl   = w_ctrl;
    assign bubble_cnt = r_bubble_cnt;
    assign flush_cnt  = r_flush_cnt;

endmodule
`default_nettype wire

// File: doc/pipe_ctrl_chain.md
Name: pipe_ctrl_chain

Overview:
Parametrised chain of pipeline control-bundle registers carrying decoded control fields (reg_wr, wr_en, rd_en, wb_sel, csr_rd, csr_wr, is_mret, ...) from decode to writeback. It generalises the single fixed stall-only control stage in four ways:
- N stages
- per-stage valid bits
- per-stage stall with upstream back-pressure and bubble insertion
- per-stage flush and a saturating bubble/flush performance counter

It sits beside the datapath pipeline registers and is driven by the hazard unit.

Parameters:
CTRL_W, 8, width of one control bundle
NUM_STG, 3, number of register stages (>=1)
ZERO_ON_BUBBLE, 1, 1: bubble/flush clears ctrl to 0; 0: ctrl retained, only valid cleared
CNT_W, 16, width of performance counters

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  new bundle available at stage-0 input
in_ctrl  in  CTRL_W  bundle from decoder
in_ready  out  1  stage 0 will accept this cycle (= ~hold[0])
stall  in  NUM_STG  stall[k] freezes stage k and all upstream stages
flush  in  NUM_STG  flush[k] turns stage k into a bubble at next edge
stg_valid  out  NUM_STG  valid bit of each stage register
stg_ctrl  out  NUM_STG*CTRL_W  raw bundle of stage k at bits [k*CTRL_W +: CTRL_W]
stg_ctrl_g  out  NUM_STG*CTRL_W  stg_ctrl ANDed with replicated stg_valid[k]
bubble_cnt  out  CNT_W  cycles with last stage invalid, saturating
flush_cnt  out  CNT_W  cycles in which any flush bit was set, saturating
cnt_clr  in  1  synchronous clear of both counters

Behaviour:
- Reset (rst_n=0, asynchronous): all stg_valid=0, all stg_ctrl=0, bubble_cnt=0, flush_cnt=0. Release is synchronous to clk.
- Effective hold: hold[k] = OR(stall[k..NUM_STG-1]). A stall propagates upstream, never downstream.
- Per stage k, per rising edge, in priority order:
  1. flush[k]=1 -> valid=0; ctrl=0 if ZERO_ON_BUBBLE else unchanged. Flush overrides hold.
  2. hold[k]=1 -> register unchanged.
  3. k=0 -> valid<=in_valid, ctrl<=in_ctrl. If in_valid=0 and ZERO_ON_BUBBLE=1, ctrl<=0.
  4. k>0 and hold[k-1]=1 -> bubble inserted: valid=0, ctrl=0 if ZERO_ON_BUBBLE else unchanged.
  5. Otherwise -> valid, ctrl <= stage k-1 contents.
- Latency: 1 cycle per stage; an unstalled bundle reaches stage NUM_STG-1 after NUM_STG edges.
- in_ready is combinational from stall: in_ready = ~hold[0]. A bundle offered while in_ready=0 is not captured; upstream must hold it.
- Flush of stage k combined with hold of stage k: stage k becomes a bubble and upstream stages stay frozen.
- Flush of all stages in one cycle empties the chain. Stage 0 does not capture in_ctrl in that cycle.
- Counters:
  - bubble_cnt increments when stg_valid[NUM_STG-1]=0.
  - flush_cnt increments when |flush=1.
  - Both saturate at 2^CNT_W-1 (no wrap).
  - cnt_clr=1 sets both to 0 that edge; clear has priority over increment.
- The counter sample for a given edge uses the pre-edge stg_valid value.
- NUM_STG=1: hold[0]=stall[0]; rule 4 is never used.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - typedef ctrl_bundle_t, a packed struct of the control fields, 8 bits total
  - localparam CTRL_W derived from $bits(ctrl_bundle_t)
  - wb_sel encodings
- One natural sub-module, pipe_ctrl_reg: a single stage with inputs hold, flush, bubble, d_valid, d_ctrl. The chain instantiates NUM_STG of them in a generate loop.
- Counters and the hold OR-chain stay in the top.

Test Plan:
- Reset/flow: assert rst_n=0 mid-stream with all stages valid -> all stg_valid=0, stg_ctrl=0 immediately. Then stream ctrl=8'hA1,8'hB2,8'hC3 with no stall -> stage 2 shows A1,B2,C3 on cycles 3,4,5.
- Back-pressure: chain holds A1/B2/C3 in stages 2/1/0, and stall[1]=1 for 2 cycles -> stages 0,1 frozen and in_ready=0. Stage 2 receives bubbles (valid=0, ctrl=0). C3 is released to stage 2 two cycles after stall drops.
- Flush priority: stall[2]=1 and flush[2]=1 in the same cycle -> stage 2 becomes a bubble, stages 0–1 frozen, flush_cnt +1.
- Mode: ZERO_ON_BUBBLE=0, stage 1 holding 8'h5A is flushed -> stg_valid[1]=0, stg_ctrl[1] stays 5A, stg_ctrl_g[1]=0.
- Counter saturation: CNT_W=4, chain empty for 20 cycles -> bubble_cnt reads 15 and holds. cnt_clr=1 together with an increment condition -> counter reads 0.
- Single stage: NUM_STG=1, stall[0]=1 -> in_ready=0 and the register holds. flush[0] with stall[0] -> valid=0.
